// File: rtl/router_ctx_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : router_ctx_sequencer
// Purpose  : per-PE context store stepped once per cycle to drive SMART router
//            crossbar selects, regbypass and start_exec_shifted.
// Revision : 1.0
// ============================================================================
module router_ctx_sequencer #(
  parameter  int NUM_CTX     = 32,
  localparam int LOG_NUM_CTX = $clog2(NUM_CTX),
  localparam int NUM_PORTS   = 7,
  localparam int CFG_WIDTH   = 53
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i__cfg_wr_en,
  input  logic [LOG_NUM_CTX-1:0] i__cfg_wr_addr,
  input  logic [CFG_WIDTH-1:0]   i__cfg_wr_data,
  input  logic                   i__start,
  input  logic                   i__stop,
  input  logic                   i__stall,
  input  logic                   i__loop_en,
  input  logic [LOG_NUM_CTX-1:0] i__last_ctx,
  output logic [NUM_PORTS-1:0]   o__sram_xbar_sel [NUM_PORTS-1:0],
  output logic [3:0]             o__regbypass,
  output logic                   o__start_exec_shifted,
  output logic                   o__done,
  output logic [15:0]            o__iter_cnt,
  output logic                   o__wr_reject
);

  localparam logic [LOG_NUM_CTX-1:0] c_PC_ONE = LOG_NUM_CTX'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [LOG_NUM_CTX-1:0] r_pc, w_pc_nxt;
  logic [LOG_NUM_CTX-1:0] r_last, w_last_nxt;
  logic [15:0]            r_iter, w_iter_nxt;
  logic                   r_prime, w_prime_nxt;
  logic [CFG_WIDTH-1:0]   r_word, w_word_nxt;
  logic                   r_sesh, w_sesh_nxt;
  logic                   r_done, w_done_nxt;
  logic                   r_wr_reject, w_wr_reject_nxt;

  logic [CFG_WIDTH-1:0]   r_mem [NUM_CTX];

  // Context memory has no reset so configuration survives a reset pulse.
  always_ff @(posedge clk) begin
    if (i__cfg_wr_en && (r_state != S_RUN)) begin
      r_mem[i__cfg_wr_addr] <= i__cfg_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_last      <= '0;
      r_iter      <= '0;
      r_prime     <= 1'b0;
      r_word      <= '0;
      r_sesh      <= 1'b0;
      r_done      <= 1'b0;
      r_wr_reject <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_last      <= w_last_nxt;
      r_iter      <= w_iter_nxt;
      r_prime     <= w_prime_nxt;
      r_word      <= w_word_nxt;
      r_sesh      <= w_sesh_nxt;
      r_done      <= w_done_nxt;
      r_wr_reject <= w_wr_reject_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_last_nxt      = r_last;
    w_iter_nxt      = r_iter;
    w_prime_nxt     = r_prime;
    w_word_nxt      = r_word;
    w_sesh_nxt      = r_sesh;
    w_done_nxt      = r_done;
    w_wr_reject_nxt = i__cfg_wr_en && (r_state == S_RUN);

    if (i__stop) begin
      w_state_nxt = S_IDLE;
      w_pc_nxt    = '0;
      w_prime_nxt = 1'b0;
      w_word_nxt  = '0;
      w_sesh_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (!i__stall) begin
            // First RUN cycle only primes the pipeline; context 0 lands a cycle later.
            if (r_prime) begin
              w_prime_nxt = 1'b0;
            end else begin
              w_word_nxt = r_mem[r_pc];
              w_sesh_nxt = 1'b1;
              if (r_pc != r_last) begin
                w_pc_nxt = r_pc + c_PC_ONE;
              end else if (i__loop_en) begin
                w_pc_nxt   = '0;
                w_iter_nxt = r_iter + 16'd1;
              end else begin
                w_state_nxt = S_DONE;
              end
            end
          end
        end
        default: begin
          if (i__start) begin
            w_state_nxt = S_RUN;
            w_pc_nxt    = '0;
            w_last_nxt  = i__last_ctx;
            w_iter_nxt  = '0;
            w_done_nxt  = 1'b0;
            w_prime_nxt = 1'b1;
            w_word_nxt  = '0;
            w_sesh_nxt  = 1'b0;
          end else if (r_state == S_DONE) begin
            w_word_nxt = '0;
            w_sesh_nxt = 1'b0;
            w_done_nxt = 1'b1;
          end
        end
      endcase
    end
  end

  for (genvar j = 0; j < NUM_PORTS; j++) begin : g_xbar_row
    assign o__sram_xbar_sel[j] = r_word[j*NUM_PORTS +: NUM_PORTS];
  end

  assign o__regbypass          = r_word[CFG_WIDTH-1 -: 4];
  assign o__start_exec_shifted = r_sesh;
  assign o__done               = r_done;
  assign o__iter_cnt           = r_iter;
  assign o__wr_reject          = r_wr_reject;

endmodule
`default_nettype wire

// File: tb/tb_router_ctx_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_ctx_sequencer
// Purpose  : directed self-checking bench for router_ctx_sequencer.
// Revision : 1.0
// ============================================================================
module tb_router_ctx_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_wr_en = 1'b0;
  logic [4:0]  cfg_wr_addr = '0;
  logic [52:0] cfg_wr_data = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        stall = 1'b0;
  logic        loop_en = 1'b0;
  logic [4:0]  last_ctx = '0;
  logic [6:0]  xbar_sel [6:0];
  logic [3:0]  regbypass;
  logic        sesh;
  logic        done;
  logic [15:0] iter_cnt;
  logic        wr_reject;
  logic [52:0] got_word;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  router_ctx_sequencer dut (
    .clk                   (clk),
    .reset                 (reset),
    .i__cfg_wr_en          (cfg_wr_en),
    .i__cfg_wr_addr        (cfg_wr_addr),
    .i__cfg_wr_data        (cfg_wr_data),
    .i__start              (start),
    .i__stop               (stop),
    .i__stall              (stall),
    .i__loop_en            (loop_en),
    .i__last_ctx           (last_ctx),
    .o__sram_xbar_sel      (xbar_sel),
    .o__regbypass          (regbypass),
    .o__start_exec_shifted (sesh),
    .o__done               (done),
    .o__iter_cnt           (iter_cnt),
    .o__wr_reject          (wr_reject)
  );

  always_comb begin
    got_word = '0;
    got_word[52:49] = regbypass;
    for (int j = 0; j < 7; j++) got_word[7*j +: 7] = xbar_sel[j];
  end

  function automatic logic [52:0] pat(input int k);
    case (k)
      0:       pat = 53'h01_0204_0810_2040;
      1:       pat = 53'h12_0408_1020_4081;
      2:       pat = 53'h0A_AAAA_5555_1234;
      3:       pat = 53'h1F_0000_FFFF_00FF;
      4:       pat = 53'h00_0000_0000_0000;
      default: pat = 53'h15_5555_AAAA_CCCC;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_ctx(input int addr, input logic [52:0] data);
    cfg_wr_en = 1'b1; cfg_wr_addr = addr[4:0]; cfg_wr_data = data;
    tick;
    cfg_wr_en = 1'b0;
  endtask

  task automatic do_start(input int last, input logic lp);
    last_ctx = last[4:0]; loop_en = lp; start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
    checks++; if (got_word !== 53'h0) begin errors++; $display("FAIL reset_word got %h exp %h", got_word, 53'h0); end
    checks++; if (sesh !== 1'b0) begin errors++; $display("FAIL reset_sesh got %b exp 0", sesh); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (iter_cnt !== 16'h0) begin errors++; $display("FAIL reset_iter got %h exp 0", iter_cnt); end
    checks++; if (wr_reject !== 1'b0) begin errors++; $display("FAIL reset_wr_reject got %b exp 0", wr_reject); end
  endtask

  task automatic test_single_pass;
    for (int k = 0; k < 4; k++) write_ctx(k, pat(k));
    do_start(3, 1'b0);
    tick;
    checks++; if (got_word !== 53'h0 || sesh !== 1'b0) begin errors++; $display("FAIL prime_cycle got %h/%b exp 0/0", got_word, sesh); end
    for (int k = 0; k < 4; k++) begin
      tick;
      checks++; if (got_word !== pat(k)) begin errors++; $display("FAIL pass_ctx%0d got %h exp %h", k, got_word, pat(k)); end
      checks++; if (sesh !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL pass_sesh%0d got %b/%b exp 1/0", k, sesh, done); end
    end
    tick;
    checks++; if (got_word !== 53'h0 || sesh !== 1'b0) begin errors++; $display("FAIL done_outputs got %h/%b exp 0/0", got_word, sesh); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_flag got %b exp 1", done); end
    tick;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_hold got %b exp 1", done); end
  endtask

  task automatic test_loop;
    do_start(1, 1'b1);
    tick;
    for (int i = 0; i < 7; i++) begin
      tick;
      checks++; if (got_word !== pat(i % 2)) begin errors++; $display("FAIL loop_ctx%0d got %h exp %h", i, got_word, pat(i % 2)); end
      checks++; if (iter_cnt !== 16'((i + 1) / 2)) begin errors++; $display("FAIL loop_iter%0d got %0d exp %0d", i, iter_cnt, (i + 1) / 2); end
    end
    stop = 1'b1;
    tick;
    stop = 1'b0; loop_en = 1'b0;
    checks++; if (got_word !== 53'h0 || sesh !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL loop_stop got %h/%b/%b exp 0/0/0", got_word, sesh, done); end
    checks++; if (iter_cnt !== 16'd3) begin errors++; $display("FAIL loop_stop_iter got %0d exp 3", iter_cnt); end
  endtask

  task automatic test_stall;
    do_start(3, 1'b0);
    tick; tick; tick; tick;
    checks++; if (got_word !== pat(2)) begin errors++; $display("FAIL stall_pre got %h exp %h", got_word, pat(2)); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++; if (got_word !== pat(2) || sesh !== 1'b1) begin errors++; $display("FAIL stall_hold%0d got %h/%b exp %h/1", i, got_word, sesh, pat(2)); end
    end
    stall = 1'b0;
    tick;
    checks++; if (got_word !== pat(3)) begin errors++; $display("FAIL stall_release got %h exp %h", got_word, pat(3)); end
    checks++; if (iter_cnt !== 16'd0) begin errors++; $display("FAIL stall_iter got %0d exp 0", iter_cnt); end
    tick;
    checks++; if (done !== 1'b1 || got_word !== 53'h0) begin errors++; $display("FAIL stall_done got %b/%h exp 1/0", done, got_word); end
  endtask

  task automatic test_wr_reject;
    do_start(1, 1'b1);
    tick; tick;
    checks++; if (got_word !== pat(0)) begin errors++; $display("FAIL rej_ctx0 got %h exp %h", got_word, pat(0)); end
    cfg_wr_en = 1'b1; cfg_wr_addr = 5'd0; cfg_wr_data = pat(5);
    tick;
    cfg_wr_en = 1'b0;
    checks++; if (wr_reject !== 1'b1) begin errors++; $display("FAIL rej_pulse got %b exp 1", wr_reject); end
    tick;
    checks++; if (wr_reject !== 1'b0) begin errors++; $display("FAIL rej_clear got %b exp 0", wr_reject); end
    checks++; if (got_word !== pat(0)) begin errors++; $display("FAIL rej_mem_kept got %h exp %h", got_word, pat(0)); end
    stop = 1'b1;
    tick;
    stop = 1'b0; loop_en = 1'b0;
    cfg_wr_en = 1'b1; cfg_wr_addr = 5'd0; cfg_wr_data = pat(5);
    do_start(0, 1'b0);
    cfg_wr_en = 1'b0;
    tick; tick;
    checks++; if (got_word !== pat(5) || sesh !== 1'b1) begin errors++; $display("FAIL wr_start_ctx0 got %h/%b exp %h/1", got_word, sesh, pat(5)); end
    tick;
    checks++; if (done !== 1'b1 || got_word !== 53'h0) begin errors++; $display("FAIL wr_start_done got %b/%h exp 1/0", done, got_word); end
    write_ctx(0, pat(0));
  endtask

  task automatic test_stop_stall;
    do_start(3, 1'b0);
    tick; tick; tick;
    checks++; if (got_word !== pat(1)) begin errors++; $display("FAIL stop_pre got %h exp %h", got_word, pat(1)); end
    stop = 1'b1; stall = 1'b1;
    tick;
    stop = 1'b0; stall = 1'b0;
    checks++; if (got_word !== 53'h0 || sesh !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL stop_stall got %h/%b/%b exp 0/0/0", got_word, sesh, done); end
    tick;
    checks++; if (got_word !== 53'h0 || done !== 1'b0) begin errors++; $display("FAIL stop_idle got %h/%b exp 0/0", got_word, done); end
  endtask

  task automatic test_reset_midrun;
    do_start(3, 1'b0);
    tick; tick; tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    checks++; if (got_word !== 53'h0 || sesh !== 1'b0 || done !== 1'b0 || iter_cnt !== 16'h0) begin errors++; $display("FAIL midrun_reset got %h/%b/%b/%h exp 0/0/0/0", got_word, sesh, done, iter_cnt); end
    do_start(3, 1'b0);
    tick;
    for (int k = 0; k < 4; k++) begin
      tick;
      checks++; if (got_word !== pat(k)) begin errors++; $display("FAIL replay_ctx%0d got %h exp %h", k, got_word, pat(k)); end
    end
    tick;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL replay_done got %b exp 1", done); end
  endtask

  task automatic test_single_ctx_wrap;
    do_start(0, 1'b1);
    tick;
    for (int n = 1; n <= 2; n++) begin
      tick;
      checks++; if (got_word !== pat(0) || iter_cnt !== 16'(n)) begin errors++; $display("FAIL single_ctx%0d got %h/%0d exp %h/%0d", n, got_word, iter_cnt, pat(0), n); end
    end
    repeat (65533) tick;
    checks++; if (iter_cnt !== 16'hFFFF || got_word !== pat(0)) begin errors++; $display("FAIL iter_max got %h/%h exp FFFF/%h", iter_cnt, got_word, pat(0)); end
    tick;
    checks++; if (iter_cnt !== 16'h0000) begin errors++; $display("FAIL iter_wrap got %h exp 0000", iter_cnt); end
    loop_en = 1'b0;
    tick;
    checks++; if (iter_cnt !== 16'h0000 || got_word !== pat(0) || sesh !== 1'b1) begin errors++; $display("FAIL loop_clear_last got %h/%h/%b exp 0/%h/1", iter_cnt, got_word, sesh, pat(0)); end
    tick;
    checks++; if (done !== 1'b1 || sesh !== 1'b0) begin errors++; $display("FAIL loop_clear_done got %b/%b exp 1/0", done, sesh); end
  endtask

  initial begin
    test_reset;
    test_single_pass;
    test_loop;
    test_stall;
    test_wr_reject;
    test_stop_stall;
    test_reset_midrun;
    test_single_ctx_wrap;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
